// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick generator.
//   SYS_CLK_HZ / FAST_HZ / SLOW_HZ : default board and time-base frequencies
//   div_width(n)                   : counter width for a modulo-n counter
package tick_gen_pkg;

  localparam int SYS_CLK_HZ = 50_000_000;
  localparam int FAST_HZ    = 100;
  localparam int SLOW_HZ    = 1;

  // $clog2(n) with a floor of 1 so a modulo-1 or modulo-2 counter still has
  // a real register bit.
  function automatic int div_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_mod_counter.sv
// Modulo-N counter stage with registered wrap strobe and half-period flag.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous restart to count 0 (beats en)
//   en   : advance enable; low holds cnt and half, forces wrap low
//   cnt  : current count, 0..N-1
//   half : registered, high while cnt is in N/2..N-1
//   wrap : registered one-cycle strobe, high in the cycle after cnt N-1 -> 0
module mod_counter
  import tick_gen_pkg::*;
#(
  parameter int N = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [div_width(N)-1:0]   cnt,
  output logic                      half,
  output logic                      wrap
);

  localparam int W = div_width(N);
  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [W-1:0] HALF_M1 = W'(N / 2 - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         half_q, half_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      half_d = 1'b0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        half_d = 1'b0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        // Second half of the period starts on the N/2-1 -> N/2 step.
        if (cnt_q == HALF_M1) half_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign half = half_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/tick_generator.sv
// Fast (FAST_HZ) and slow (SLOW_HZ) time bases derived from the system clock.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   run       : count enable; low freezes both time bases
//   sync_clr  : synchronous phase restart (beats run)
//   tick_fast : one-cycle strobe every CLK_FREQ_HZ/FAST_HZ cycles
//   tick_slow : one-cycle strobe at SLOW_HZ, coincident with a tick_fast
//   sq_fast   : FAST_HZ square wave, 50% duty
//   sq_slow   : SLOW_HZ square wave, 50% duty
// All outputs come straight from registers inside the counter stages.
module tick_generator #(
  parameter int CLK_FREQ_HZ = tick_gen_pkg::SYS_CLK_HZ,
  parameter int FAST_HZ     = tick_gen_pkg::FAST_HZ,
  parameter int SLOW_HZ     = tick_gen_pkg::SLOW_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sync_clr,
  output logic tick_fast,
  output logic tick_slow,
  output logic sq_fast,
  output logic sq_slow
);

  import tick_gen_pkg::*;

  localparam int FAST_DIV = CLK_FREQ_HZ / FAST_HZ;
  localparam int RATIO    = FAST_HZ / SLOW_HZ;
  localparam int FW       = div_width(FAST_DIV);
  localparam int SW       = div_width(RATIO);

  if (SLOW_HZ <= 0 || FAST_HZ <= SLOW_HZ ||
      (CLK_FREQ_HZ % (2 * FAST_HZ)) != 0 ||
      (FAST_HZ % SLOW_HZ) != 0 || ((FAST_HZ / SLOW_HZ) % 2) != 0) begin : g_param_check
    $error("tick_generator: CLK_FREQ_HZ must be a multiple of 2*FAST_HZ and FAST_HZ/SLOW_HZ an even integer");
  end

  logic [FW-1:0] pre_cnt;
  logic [SW-1:0] sec_cnt;
  logic          fast_last;

  // The slow stage steps on the same edge the fast stage wraps, so its
  // enable is the fast terminal-count condition rather than the registered
  // tick (which would be one cycle late and break tick coincidence).
  assign fast_last = run && (pre_cnt == FW'(FAST_DIV - 1));

  mod_counter #(.N(FAST_DIV)) u_fast (
    .clk  (clk),
    .rst  (rst),
    .clr  (sync_clr),
    .en   (run),
    .cnt  (pre_cnt),
    .half (sq_fast),
    .wrap (tick_fast)
  );

  mod_counter #(.N(RATIO)) u_slow (
    .clk  (clk),
    .rst  (rst),
    .clr  (sync_clr),
    .en   (fast_last),
    .cnt  (sec_cnt),
    .half (sq_slow),
    .wrap (tick_slow)
  );

  // Counters have no overflow state beyond their terminal value.
  a_pre_range : assert property (@(posedge clk) disable iff (rst)
                                 pre_cnt <= FW'(FAST_DIV - 1));
  a_sec_range : assert property (@(posedge clk) disable iff (rst)
                                 sec_cnt <= SW'(RATIO - 1));

endmodule
